// File: rtl/tile_ram_arbiter_pkg.sv
// Shared constants, state encoding and helpers for the tile RAM arbiter.
package tile_ram_pkg;

    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 8;

    localparam int REQ_GAME    = 0;
    localparam int REQ_SHUFFLE = 1;
    localparam int REQ_LOG     = 2;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    function automatic int rr_next(input int id, input int n);
        return (id + 1 >= n) ? 0 : id + 1;
    endfunction

endpackage

// File: rtl/tile_ram_arbiter_if.sv
// Requester-side and RAM-side bus of the tile RAM arbiter.
interface tile_ram_arbiter_if
    import tile_ram_pkg::*;
#(
    parameter int NREQ   = 3,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();

    logic [NREQ-1:0]        req;
    logic [NREQ-1:0]        lock;
    logic [NREQ-1:0]        we;
    logic [NREQ*ADDR_W-1:0] addr;
    logic [NREQ*DATA_W-1:0] wdata;
    logic [NREQ-1:0]        gnt;
    logic [NREQ-1:0]        rvalid;
    logic [DATA_W-1:0]      rdata;
    logic                   owner_locked;
    logic [ADDR_W-1:0]      ram_addr;
    logic                   ram_we;
    logic [DATA_W-1:0]      ram_wdata;
    logic [DATA_W-1:0]      ram_rdata;

    modport master (
        output req, lock, we, addr, wdata, ram_rdata,
        input  gnt, rvalid, rdata, owner_locked, ram_addr, ram_we, ram_wdata
    );

    modport slave (
        input  req, lock, we, addr, wdata, ram_rdata,
        output gnt, rvalid, rdata, owner_locked, ram_addr, ram_we, ram_wdata
    );

endinterface

// File: rtl/tile_ram_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible index at or after the pointer.
module rr_pick #(
    parameter int NREQ  = 3,
    parameter int PTR_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  i_elig,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [NREQ-1:0]  o_win,
    output logic             o_found,
    output logic [PTR_W-1:0] o_win_id
);

    int w_j;

    always_comb begin
        o_win    = '0;
        o_found  = 1'b0;
        o_win_id = '0;
        w_j      = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_j = int'(i_ptr) + k;
            if (w_j >= NREQ) w_j = w_j - NREQ;
            if (!o_found && i_elig[w_j]) begin
                o_found    = 1'b1;
                o_win[w_j] = 1'b1;
                o_win_id   = PTR_W'(w_j);
            end
        end
    end

endmodule

// File: rtl/tile_ram_arbiter.sv
// Round-robin arbiter with RMW lock for the tile board RAM A port.
//   state  | meaning
//   IDLE   | no lock held, round-robin among all requesters
//   LOCKED | r_owner holds the port, only its req is eligible
module tile_ram_arbiter
    import tile_ram_pkg::*;
#(
    parameter int NREQ   = 3,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int RD_LAT = 1
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    tile_ram_arbiter_if.slave io_bus
);

    localparam int PTR_W = $clog2(NREQ);

    arb_state_t        r_state, w_state_nxt;
    logic [PTR_W-1:0]  r_owner, w_owner_nxt;
    logic [PTR_W-1:0]  r_ptr, w_ptr_nxt;
    logic [NREQ-1:0]   r_gnt, r_rvalid;
    logic [PTR_W-1:0]  r_gnt_id;
    logic [ADDR_W-1:0] r_ram_addr;
    logic              r_ram_we;
    logic [DATA_W-1:0] r_ram_wdata, r_rdata;
    logic              r_pipe_v  [RD_LAT];
    logic [PTR_W-1:0]  r_pipe_id [RD_LAT];

    logic [NREQ-1:0]   w_elig, w_win_oh;
    logic              w_found;
    logic [PTR_W-1:0]  w_win_id;

    // A requester granted this cycle is masked so it cannot win back-to-back.
    always_comb begin
        w_elig = io_bus.req & ~r_gnt;
        if (r_state == LOCKED) w_elig = w_elig & (NREQ'(1) << r_owner);
    end

    rr_pick #(.NREQ(NREQ), .PTR_W(PTR_W)) u_pick (
        .i_elig   (w_elig),
        .i_ptr    (r_ptr),
        .o_win    (w_win_oh),
        .o_found  (w_found),
        .o_win_id (w_win_id)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        if (w_found) begin
            if (r_state == IDLE) w_ptr_nxt = PTR_W'(rr_next(int'(w_win_id), NREQ));
            if (io_bus.lock[w_win_id]) begin
                w_state_nxt = LOCKED;
                w_owner_nxt = w_win_id;
            end else begin
                w_state_nxt = IDLE;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state <= IDLE;
            r_owner <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_gnt       <= '0;
            r_gnt_id    <= '0;
            r_ram_addr  <= '0;
            r_ram_we    <= 1'b0;
            r_ram_wdata <= '0;
            r_rvalid    <= '0;
            r_rdata     <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                r_pipe_v[k]  <= 1'b0;
                r_pipe_id[k] <= '0;
            end
        end else begin
            r_gnt    <= w_win_oh;
            r_gnt_id <= w_win_id;
            r_ram_we <= w_found & io_bus.we[w_win_id];
            if (w_found) begin
                r_ram_addr  <= io_bus.addr[int'(w_win_id)*ADDR_W +: ADDR_W];
                r_ram_wdata <= io_bus.wdata[int'(w_win_id)*DATA_W +: DATA_W];
            end
            // Pipeline tracks reads issued in the gnt cycle until ram_rdata is valid.
            r_pipe_v[0]  <= (|r_gnt) & ~r_ram_we;
            r_pipe_id[0] <= r_gnt_id;
            for (int k = 1; k < RD_LAT; k++) begin
                r_pipe_v[k]  <= r_pipe_v[k-1];
                r_pipe_id[k] <= r_pipe_id[k-1];
            end
            r_rvalid <= '0;
            if (r_pipe_v[RD_LAT-1]) begin
                r_rvalid <= NREQ'(1) << r_pipe_id[RD_LAT-1];
                r_rdata  <= io_bus.ram_rdata;
            end
        end
    end

    assign io_bus.gnt          = r_gnt;
    assign io_bus.rvalid       = r_rvalid;
    assign io_bus.rdata        = r_rdata;
    assign io_bus.owner_locked = (r_state == LOCKED);
    assign io_bus.ram_addr     = r_ram_addr;
    assign io_bus.ram_we       = r_ram_we;
    assign io_bus.ram_wdata    = r_ram_wdata;

endmodule

// File: doc/tile_ram_arbiter.md
Name: tile_ram_arbiter

Overview:
Shares the single read/write port of the tile board RAM between up to NREQ game-side requesters: ingame FSM, board shuffler, and score/state logger. Uses round-robin arbitration with a lock for atomic read-modify-write sequences such as tile swaps. Returns read data to the winning requester with fixed latency. Sits between the requesters and the RAM's A port; the VGA read port (C) is not arbitrated.

Parameters:
NREQ, 3, number of requesters (2..8)
ADDR_W, 4, tile RAM address width (16 tiles)
DATA_W, 8, tile RAM word width
RD_LAT, 1, RAM read latency in cycles from ram_addr to ram_rdata (1..3)

Ports:
CLOCK_50  in  1  system clock
reset  in  1  synchronous, active-high reset
req  in  NREQ  per-requester access request; held until gnt seen
lock  in  NREQ  sampled with req; 1 = keep ownership after this access
we  in  NREQ  1 = write, 0 = read
addr  in  NREQ*ADDR_W  flattened addresses; requester i at [i*ADDR_W +: ADDR_W]
wdata  in  NREQ*DATA_W  flattened write data
gnt  out  NREQ  one-hot, 1-cycle pulse: access accepted and presented to RAM this cycle
rvalid  out  NREQ  one-hot, 1-cycle pulse: rdata valid for requester i
rdata  out  DATA_W  registered read data
owner_locked  out  1  a lock is currently held
ram_addr  out  ADDR_W  to RAM
ram_we  out  1  to RAM
ram_wdata  out  DATA_W  to RAM
ram_rdata  in  DATA_W  from RAM

Behaviour:
- Reset (synchronous, active-high) clears gnt, rvalid, rdata, ram_addr, ram_we, ram_wdata, and owner_locked to 0. RR pointer goes to 0. State goes to IDLE. The read pipeline is flushed, so no rvalid is issued for accesses in flight. Reset mid-lock releases the lock.
- States:
  - IDLE: no lock held.
  - LOCKED: owner id L is held.
- Arbitration in cycle N:
  - Eligible set = req masked by "gnt[i] high in cycle N", so a requester is never granted on consecutive cycles.
  - In IDLE: winner = first eligible index at or after the RR pointer, wrapping modulo NREQ.
  - In LOCKED: only req[L] is eligible; all others wait regardless of pointer.
- Issue in cycle N+1 (registered):
  - gnt[winner] = 1.
  - ram_addr, ram_we, and ram_wdata take the winner's values sampled at N.
  - With no winner, ram_we = 0 and ram_addr/ram_wdata hold their previous values.
- Pointer: after a grant to i, pointer = (i+1) mod NREQ. Pointer is unchanged while LOCKED.
- Lock transitions:
  - A granted access with lock=1 goes IDLE->LOCKED with L=i, or stays LOCKED.
  - A granted access by L with lock=0 goes LOCKED->IDLE, effective for arbitration in the next cycle.
  - owner_locked = (state==LOCKED), registered.
- Reads: a shift pipeline of depth RD_LAT carries {valid-read, id}. ram_rdata is captured into rdata, and rvalid[id] pulses, RD_LAT+1 cycles after the gnt cycle. Example with RD_LAT=1: gnt at T, rvalid/rdata at T+2.
- Writes produce no rvalid.
- Throughput is one access per cycle when two or more requesters alternate; a single requester gets at most one access every 2 cycles.
- Dropping req before gnt withdraws the request with no side effect. Changing addr/we/wdata while waiting is allowed; the values sampled in the arbitration cycle win.
- Requesters with index >= NREQ do not exist; there is no X propagation from unused bits.

Decomposition:
- Package tile_ram_pkg holds:
  - ADDR_W and DATA_W defaults.
  - Requester id constants: REQ_GAME=0, REQ_SHUFFLE=1, REQ_LOG=2.
  - State encoding: IDLE=1'b0, LOCKED=1'b1.
- Sub-module rr_pick (combinational): inputs eligible mask and pointer; outputs one-hot winner and found flag. It is reused by future arbiters.

Test Plan:
- Reset then a single read: req[0], we=0, addr=5, with RAM[5]=8'h3C. Expect gnt[0] at T, ram_addr=5 and ram_we=0 at T, rvalid[0]=1 with rdata=8'h3C at T+2.
- All three requesters hold req continuously (reads) from reset. Expect grants in order 0,1,2,0,1,2 on consecutive cycles and never two same-index grants adjacent.
- Lock swap: req[1] with lock=1 reads addr 2, then reads addr 9 with lock=1, writes 2 with lock=1, writes 9 with lock=0, while req[0] and req[2] are held high. Expect no gnt[0]/gnt[2] until the cycle after the final gnt[1], and owner_locked=1 throughout. The next grant is 2 (pointer=2).
- Write then read: req[2] writes addr 15 = 8'hA5, then reads addr 15. Expect ram_we=1 only in the first gnt cycle, then rvalid[2] with rdata=8'hA5.
- Reset asserted while LOCKED with a read in flight. Expect gnt=0, rvalid=0, and owner_locked=0 the cycle after reset. No rvalid ever appears for the flushed read, and the first post-reset grant follows pointer 0.
- Withdrawal: req[1] pulsed for 1 cycle while req[0] wins that cycle. Expect gnt[1] never asserted and ram_we unchanged by requester 1.
